// File: rtl/ks_sub_pipe.sv
// Three-stage pipelined 8-bit Kogge-Stone subtractor (diff = a - b - bin) with
// borrow-out, signed overflow and a valid/ready handshake on both sides.
module ks_sub_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready
);

    logic       en1_s, en2_s, en3_s;
    logic       v1_r, v2_r, v3_r;

    // Prefix vectors are 9 wide: index 0 carries cin, index i+1 is operand bit i.
    logic [7:0] pre_p_s;
    logic [8:0] g0_s, p0_s, g1_s, p1_s, g2_s, g3_s;
    logic [8:4] p2_s;
    logic       p3_top_s, cout_s, ovf_s;
    logic [7:0] diff_s;

    logic [7:0] p1_r, p2_r;
    logic [8:0] gg1_r, gp1_r, gg2_r;
    logic [8:4] gp2_r;
    logic       a7_1_r, b7_1_r, a7_2_r, b7_2_r;
    logic [7:0] diff_r;
    logic       bout_r, ovf_r;

    // Backpressure chain: a stage may advance when empty or when its successor advances.
    always_comb begin
        en3_s = ~v3_r | out_ready;
        en2_s = ~v2_r | en3_s;
        en1_s = ~v1_r | en2_s;
    end

    assign in_ready  = en1_s;
    assign out_valid = v3_r;
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign ovf       = ovf_r;

    // Pre-processing on a + ~b + ~bin, then prefix row 1 (distance 1).
    always_comb begin
        pre_p_s = a ^ ~b;
        g0_s    = {a & ~b, ~bin};
        p0_s    = {pre_p_s, 1'b0};
        g1_s    = g0_s;
        p1_s    = p0_s;
        for (int j = 1; j < 9; j++) begin
            g1_s[j] = g0_s[j] | (p0_s[j] & g0_s[j-1]);
            p1_s[j] = p0_s[j] & p0_s[j-1];
        end
    end

    // Prefix row 2 (distance 2); only group-propagate of unresolved spans is kept.
    always_comb begin
        g2_s = gg1_r;
        p2_s = gp1_r[8:4];
        for (int j = 2; j < 9; j++) begin
            g2_s[j] = gg1_r[j] | (gp1_r[j] & gg1_r[j-2]);
        end
        for (int j = 4; j < 9; j++) begin
            p2_s[j] = gp1_r[j] & gp1_r[j-2];
        end
    end

    // Prefix row 3 (distance 4), post XOR, final grey cell for cout, and flags.
    always_comb begin
        g3_s = gg2_r;
        for (int j = 4; j < 9; j++) begin
            g3_s[j] = gg2_r[j] | (gp2_r[j] & gg2_r[j-4]);
        end
        p3_top_s = gp2_r[8] & gp2_r[4];
        diff_s   = p2_r ^ g3_s[7:0];
        cout_s   = g3_s[8] | (p3_top_s & g3_s[0]);
        ovf_s    = (a7_2_r ^ b7_2_r) & (a7_2_r ^ diff_s[7]);
    end

    // Stage 1 register: row-1 prefix state and operand sign bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r   <= 1'b0;
            p1_r   <= 8'h00;
            gg1_r  <= 9'h000;
            gp1_r  <= 9'h000;
            a7_1_r <= 1'b0;
            b7_1_r <= 1'b0;
        end else if (en1_s) begin
            v1_r   <= in_valid;
            p1_r   <= pre_p_s;
            gg1_r  <= g1_s;
            gp1_r  <= p1_s;
            a7_1_r <= a[7];
            b7_1_r <= b[7];
        end
    end

    // Stage 2 register: row-2 prefix state, bit propagates and sign bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_r   <= 1'b0;
            p2_r   <= 8'h00;
            gg2_r  <= 9'h000;
            gp2_r  <= 5'h00;
            a7_2_r <= 1'b0;
            b7_2_r <= 1'b0;
        end else if (en2_s) begin
            v2_r   <= v1_r;
            p2_r   <= p1_r;
            gg2_r  <= g2_s;
            gp2_r  <= p2_s;
            a7_2_r <= a7_1_r;
            b7_2_r <= b7_1_r;
        end
    end

    // Stage 3 output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3_r   <= 1'b0;
            diff_r <= 8'h00;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (en3_s) begin
            v3_r   <= v2_r;
            diff_r <= diff_s;
            bout_r <= ~cout_s;
            ovf_r  <= ovf_s;
        end
    end

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Scoreboard bench for ks_sub_pipe: directed vectors, streaming, backpressure,
// mid-operation reset and a random stall soak.
module tb_ks_sub_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       bin = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, bout, ovf;
    logic [7:0] diff;

    ks_sub_pipe dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin),
        .in_valid(in_valid), .in_ready(in_ready),
        .diff(diff), .bout(bout), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0, n_acc = 0;
    bit   chk_lat = 1'b0, use_tab = 1'b0, hold_pend = 1'b0;
    logic [7:0] hold_d;
    logic       hold_bo, hold_ov;
    logic [7:0] tab_d;
    logic       tab_bo, tab_ov;

    logic [7:0] ta [5] = '{8'h05, 8'h00, 8'h80, 8'h7F, 8'h10};
    logic [7:0] tb [5] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'h0F};
    logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] td [5] = '{8'h02, 8'hFF, 8'h7F, 8'h80, 8'h00};
    logic       tbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        exp_t e;
        logic [8:0] r;
        int sx, sy, s;
        r    = {1'b0, x} - {1'b0, y} - {8'd0, c};
        sx   = $signed(x);
        sy   = $signed(y);
        s    = sx - sy - int'(c);
        e.d  = r[7:0];
        e.bo = r[8];
        e.ov = (s > 127) || (s < -128);
        e.cyc = cyc;
        return e;
    endfunction

    // One clock: sample at the falling edge, update scoreboard, advance past the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (hold_pend && out_valid) begin
                check("hold_diff", {24'd0, diff}, {24'd0, hold_d});
                check("hold_bout", {31'd0, bout}, {31'd0, hold_bo});
                check("hold_ovf",  {31'd0, ovf},  {31'd0, hold_ov});
            end
            hold_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("diff", {24'd0, diff}, {24'd0, e.d});
                    check("bout", {31'd0, bout}, {31'd0, e.bo});
                    check("ovf",  {31'd0, ovf},  {31'd0, e.ov});
                    if (chk_lat) check("latency", cyc - e.cyc, 32'd3);
                end
            end else if (out_valid) begin
                hold_pend = 1'b1;
                hold_d    = diff;
                hold_bo   = bout;
                hold_ov   = ovf;
            end
            if (in_valid && in_ready) begin
                e = model(a, b, bin);
                if (use_tab) begin
                    e.d  = tab_d;
                    e.bo = tab_bo;
                    e.ov = tab_ov;
                end
                sb.push_back(e);
                n_acc++;
            end
        end else begin
            hold_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int n0;
        // Reset state
        repeat (2) step();
        rst_n = 1'b1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors, one at a time
        chk_lat = 1'b1;
        use_tab = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = ta[i]; b = tb[i]; bin = tc[i];
            tab_d = td[i]; tab_bo = tbo[i]; tab_ov = tov[i];
            in_valid = 1'b1;
            n0 = n_acc;
            step();
            check("dir_accept", n_acc - n0, 32'd1);
            drain("dir_drain");
        end
        use_tab = 1'b0;

        // Back-to-back stream
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            in_valid = 1'b1;
            check("tp_in_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        drain("tp_drain");
        chk_lat = 1'b0;

        // Backpressure from an empty pipe
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            step();
        end
        check("bp_accepts", n_acc - n0, 32'd3);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        drain("bp_drain");

        // Reset with three operations in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            step();
        end
        check("mr_full", sb.size(), 32'd3);
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        sb.delete();
        rst_n = 1'b1;
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_diff", {24'd0, diff}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) step();

        // Random stall soak
        for (int i = 0; i < 10000; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain("soak_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
